// File: rtl/seq_ser_pkg.sv
// Shared types and constants for the bit serializer slice.
package seq_ser_pkg;

  localparam int unsigned SEQ_SER_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/seq_ser_hold_reg.sv
// One-deep holding register: captures a word while the shifter is busy.
module seq_ser_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_q;
  logic         full_q;

  // Load and unload are mutually exclusive: load only while empty, unload only while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding a sequence detector, with a 1-deep input buffer.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after each word.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int unsigned W         = SEQ_SER_W_DEF,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         x,
  output logic         x_valid,
  output logic         x_parity,
  output logic         word_done
);

`ifdef SEQ_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int unsigned CW   = $clog2(W + 1);
  localparam int unsigned LAST = PAR_EN ? W : W - 1;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] sr_q, sr_d;
  logic         par_q, par_d;
  logic         x_q, x_d;
  logic         x_valid_q, x_valid_d;
  logic         x_parity_q, x_parity_d;
  logic         word_done_q, word_done_d;

  logic         hold_full;
  logic [W-1:0] hold_data;
  logic         hold_load;
  logic         hold_unload;

  logic         accept;
  logic         on_last;
  logic         par_slot;
  logic         do_load;
  logic [W-1:0] load_word;

  seq_ser_hold_reg #(.W(W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .load_i   (hold_load),
    .unload_i (hold_unload),
    .data_i   (in_data),
    .data_o   (hold_data),
    .full_o   (hold_full)
  );

  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;
  assign on_last  = (state_q == SHIFT) && (cnt_q == CW'(LAST));
  assign par_slot = PAR_EN && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      x_parity_q  <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      x_parity_q  <= x_parity_d;
      word_done_q <= word_done_d;
    end
  end

  // Next state and registered outputs; cnt_q is the index of the bit currently on x.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    x_d         = 1'b0;
    x_valid_d   = 1'b0;
    x_parity_d  = 1'b0;
    word_done_d = 1'b0;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    do_load     = 1'b0;
    load_word   = in_data;

    case (state_q)
      IDLE: begin
        if (accept) do_load = 1'b1;
      end
      SHIFT: begin
        if (on_last) begin
          if (hold_full) begin
            do_load     = 1'b1;
            load_word   = hold_data;
            hold_unload = 1'b1;
          end else if (accept) begin
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          if (accept) hold_load = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          x_valid_d   = 1'b1;
          word_done_d = (cnt_d == CW'(LAST));
          if (par_slot) begin
            x_d        = par_q;
            x_parity_d = 1'b1;
          end else begin
            x_d  = LSB_FIRST ? sr_q[0] : sr_q[W-1];
            sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // First bit goes straight to x; the shifter keeps the remaining bits.
    if (do_load) begin
      state_d   = SHIFT;
      cnt_d     = '0;
      x_valid_d = 1'b1;
      x_d       = LSB_FIRST ? load_word[0] : load_word[W-1];
      sr_d      = LSB_FIRST ? (load_word >> 1) : (load_word << 1);
      par_d     = ^load_word;
    end

    if (clr) begin
      state_d     = IDLE;
      cnt_d       = '0;
      x_d         = 1'b0;
      x_valid_d   = 1'b0;
      x_parity_d  = 1'b0;
      word_done_d = 1'b0;
      hold_load   = 1'b0;
      hold_unload = 1'b0;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign x_parity  = x_parity_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances against a token-queue model.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       rdy_m, x_m, xv_m, xp_m, wd_m;
  logic       rdy_l, x_l, xv_l, xp_l, wd_l;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_bit_serializer #(.W(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .x_parity(xp_m), .word_done(wd_m)
  );

  seq_bit_serializer #(.W(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .x_parity(xp_l), .word_done(wd_l)
  );

  typedef struct packed {
    logic b;
    logic p;
  } tok_t;

  // Model: remaining stream tokens of the current word (front is on x now) plus one held word.
  tok_t       cur_m[$];
  tok_t       cur_l[$];
  bit         held;
  logic [7:0] hword;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] cap_m, cap_l;

  function automatic void push_word(input logic [7:0] d);
    cur_m.delete();
    cur_l.delete();
    for (int i = 0; i < 8; i++) begin
      cur_m.push_back('{b: d[7-i], p: 1'b0});
      cur_l.push_back('{b: d[i], p: 1'b0});
    end
`ifdef SEQ_SER_PARITY_EN
    cur_m.push_back('{b: ^d, p: 1'b1});
    cur_l.push_back('{b: ^d, p: 1'b1});
`endif
  endfunction

  function automatic void model_reset();
    cur_m.delete();
    cur_l.delete();
    held = 1'b0;
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] d, input bit c);
    bit xfer;
    bit last;
    xfer = v && !held;
    if (c) begin
      model_reset();
      return;
    end
    last = (cur_m.size() <= 1);
    if (cur_m.size() > 0) begin
      void'(cur_m.pop_front());
      void'(cur_l.pop_front());
    end
    if (last) begin
      if (held) begin
        push_word(hword);
        held = 1'b0;
      end else if (xfer) begin
        push_word(d);
      end
    end else if (xfer) begin
      held  = 1'b1;
      hword = d;
    end
  endfunction

  task automatic chk1(input string tag, input logic act, input logic exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic ev, ebm, ebl, epm, epl, ed;
    ev  = (cur_m.size() > 0);
    ebm = ev ? cur_m[0].b : 1'b0;
    ebl = ev ? cur_l[0].b : 1'b0;
    epm = ev ? cur_m[0].p : 1'b0;
    epl = ev ? cur_l[0].p : 1'b0;
    ed  = (cur_m.size() == 1);
    chk1({tag, ".m.x"},         x_m,   ebm);
    chk1({tag, ".m.x_valid"},   xv_m,  ev);
    chk1({tag, ".m.x_parity"},  xp_m,  epm);
    chk1({tag, ".m.word_done"}, wd_m,  ed);
    chk1({tag, ".m.in_ready"},  rdy_m, !held);
    chk1({tag, ".l.x"},         x_l,   ebl);
    chk1({tag, ".l.x_valid"},   xv_l,  ev);
    chk1({tag, ".l.x_parity"},  xp_l,  epl);
    chk1({tag, ".l.word_done"}, wd_l,  ed);
    chk1({tag, ".l.in_ready"},  rdy_l, !held);
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit c, input string tag);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    model_edge(v, d, c);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Single word 0x0A; also capture the raw bit order from each instance
    cyc(1'b1, 8'h0A, 1'b0, "w0a_load");
    cap_m = 8'h00;
    cap_l = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cap_m = {cap_m[6:0], x_m};
      cap_l = {cap_l[6:0], x_l};
      cyc(1'b0, 8'h00, 1'b0, "w0a");
    end
    tests++;
    assert (cap_m === 8'h0A) else begin
      fails++;
      $error("FAIL msb_order: got %h, expected %h", cap_m, 8'h0A);
    end
    tests++;
    assert (cap_l === 8'h50) else begin
      fails++;
      $error("FAIL lsb_order: got %h, expected %h", cap_l, 8'h50);
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b0, "w0a_idle");

    // Back-to-back A5 then 3C with in_valid held while the hold register is full
    cyc(1'b1, 8'hA5, 1'b0, "b2b_a5");
    repeat (7) cyc(1'b1, 8'h3C, 1'b0, "b2b_3c");
    repeat (20) cyc(1'b0, 8'h00, 1'b0, "b2b_drain");

    // Flush in cycle 4 of 0xFF with 0x11 held
    cyc(1'b1, 8'hFF, 1'b0, "clr_ff");
    cyc(1'b1, 8'h11, 1'b0, "clr_11");
    repeat (2) cyc(1'b0, 8'h00, 1'b0, "clr_run");
    cyc(1'b1, 8'h99, 1'b1, "clr_hit");
    repeat (12) cyc(1'b0, 8'h00, 1'b0, "clr_after");

    // Asynchronous reset mid-word with a held word, then a clean 0x01
    cyc(1'b1, 8'hC3, 1'b0, "ar_c3");
    cyc(1'b1, 8'h5A, 1'b0, "ar_5a");
    repeat (2) cyc(1'b0, 8'h00, 1'b0, "ar_run");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
    cyc(1'b1, 8'h01, 1'b0, "ar_01");
    repeat (11) cyc(1'b0, 8'h00, 1'b0, "ar_01_run");

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 49) == 0, "rand");
    end
    repeat (12) cyc(1'b0, 8'h00, 1'b0, "final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the data word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 0; 0 selects MSB-first shift order, 1 selects LSB-first.
REQ-003 The block SHALL have input clk, 1 bit, the clock; all state changes on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have input clr, 1 bit, a synchronous flush that discards all buffered and in-flight data.
REQ-006 The block SHALL have input in_valid, 1 bit, meaning in_data holds a word offered for transfer.
REQ-007 The block SHALL have input in_data, W bits, the parallel word.
REQ-008 The block SHALL have output in_ready, 1 bit, meaning the block accepts a word this cycle.
REQ-009 The block SHALL have output x, 1 bit, the serial bit driven to the downstream sequence detector.
REQ-010 The block SHALL have output x_valid, 1 bit, meaning x carries a real stream bit this cycle.
REQ-011 The block SHALL have output x_parity, 1 bit, meaning the current x is a parity bit, not a data bit.
REQ-012 The block SHALL have output word_done, 1 bit, a one-cycle pulse on the last bit of each word.

Function
REQ-013 Transfer SHALL occur at a rising edge where in_valid=1 and in_ready=1; in_valid is not gated by in_ready.
REQ-014 Storage SHALL be a shift register with bit counter plus one 1-deep holding register; in_ready = !hold_full.
REQ-015 FSM SHALL have two states: IDLE (shifter empty) and SHIFT (shifter holds a word).
REQ-016 A word accepted at edge N while in IDLE, or while the shifter is on its last bit, SHALL load the shifter directly; its first bit appears on x with x_valid=1 in cycle N+1.
REQ-017 A word accepted while in SHIFT, not on the last bit, SHALL go to the holding register.
REQ-018 On the last bit with hold_full=1, the held word SHALL move into the shifter at that edge, giving gap-free output and clearing hold_full.
REQ-019 Each word SHALL occupy exactly W consecutive x_valid cycles (W+1 with parity); bit order SHALL follow LSB_FIRST.
REQ-020 In SHIFT, with no data available at the last bit, the FSM SHALL return to IDLE; in IDLE, x_valid=0 and x=0.
REQ-021 x, x_valid, x_parity and word_done SHALL be registered outputs, with no combinational path from inputs.
REQ-022 clr=1 SHALL, at the next edge, empty the shifter and the holding register and enter IDLE; clr overrides a simultaneous transfer, which is dropped.
REQ-023 The bit counter SHALL be $clog2(W+1) bits wide and wrap to 0 on word completion.

Reset
REQ-024 While rst_n=0 the block SHALL hold: state=IDLE, hold_full=0, counter=0, x=0, x_valid=0, x_parity=0, word_done=0, in_ready=1.
REQ-025 Reset mid-word SHALL abort the word; no partial bits SHALL appear after release.

Configuration
REQ-026 With macro SEQ_SER_PARITY_EN defined, each word SHALL be followed by one even-parity bit (XOR of the word's W bits) with x_parity=1, and word_done SHALL pulse on the parity bit.
REQ-027 Without SEQ_SER_PARITY_EN, no parity bit SHALL be emitted, x_parity SHALL be tied 0, and word_done SHALL pulse on data bit W-1.

Structure
REQ-028 Package seq_ser_pkg SHALL hold the state enum (IDLE, SHIFT) and the default width constant SEQ_SER_W_DEF=8.
REQ-029 The 1-deep holding register (data plus full flag, load/unload) SHALL be sub-module seq_ser_hold_reg; all other logic stays in seq_bit_serializer.

Verification
REQ-030 Config W=8, MSB-first, no parity; drive one word 8'h0A at edge N -> x=0,0,0,0,1,0,1,0 in cycles N+1..N+8, x_valid=1 throughout, word_done in cycle N+8, then IDLE.
REQ-031 Drive 8'hA5 then 8'h3C back-to-back with in_valid held -> 16 contiguous x_valid cycles; in_ready=0 while the hold register is full; bits 10100101 00111100.
REQ-032 With LSB_FIRST=1, drive 8'h0A -> x=0,1,0,1,0,0,0,0.
REQ-033 Assert clr in cycle 4 of word 8'hFF with a held word pending -> x_valid=0 from the next cycle, in_ready=1, neither word resumes.
REQ-034 With SEQ_SER_PARITY_EN, drive 8'h07 -> 8 data bits, then x=1 with x_parity=1, word_done on the 9th bit.
REQ-035 Pull rst_n low asynchronously mid-word -> all outputs at their reset values immediately; after release, 8'h01 serializes cleanly.
